// File: rtl/bios_arb_pkg.sv
// bios_arb_pkg: shared state, grant ids and byte alignment for the BIOS ROM arbiter
package bios_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LD = 1'b1;
  function automatic logic [31:0] byte_align(input logic [31:0] word, input logic [1:0] offset);
    byte_align = word >> {offset, 3'b000};
  endfunction
endpackage

// File: rtl/bios_arbiter_rr_arb2.sv
// rr_arb2: combinational two-input round-robin arbiter
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant,
  output logic       winner
);
  assign winner = &valid ? ~last_grant : valid[1];
  assign grant  = (en && |valid) ? (winner ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: rtl/bios_arbiter.sv
// bios_arbiter: round-robin sharing of the BIOS ROM read port between IF and LD
module bios_arbiter
  import bios_arb_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  input  logic              if_resp_ready,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              ld_req_valid,
  output logic              ld_req_ready,
  input  logic [ADDR_W-1:0] ld_req_addr,
  output logic              ld_resp_valid,
  input  logic              ld_resp_ready,
  output logic [DATA_W-1:0] ld_resp_data,
  output logic              mem_en,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] resp_q;
  logic              gnt_q, last_grant, winner, accept, resp_hs;
  logic [1:0]        grant;
  rr_arb2 u_arb (
    .valid      ({ld_req_valid, if_req_valid}),
    .last_grant (last_grant),
    .en         (state == IDLE),
    .grant      (grant),
    .winner     (winner)
  );
  assign accept  = |grant;
  assign resp_hs = gnt_q == GNT_LD ? ld_resp_ready : if_resp_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (accept ? READ : IDLE) :
               state == READ ? CAPT :
               state == CAPT ? RESP :
               (resp_hs ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q     <= '0;
      gnt_q      <= GNT_IF;
      last_grant <= GNT_LD;
      resp_q     <= '0;
    end else begin
      if (accept) begin
        addr_q     <= winner == GNT_LD ? ld_req_addr : if_req_addr;
        gnt_q      <= winner;
        last_grant <= winner;
      end
      if (state == CAPT) resp_q <= byte_align(mem_rdata, addr_q[1:0]);
    end
  always_comb begin
    if_req_ready  = grant[0];
    ld_req_ready  = grant[1];
    mem_en        = state == READ;
    mem_addr      = state == READ ? addr_q[ADDR_W-1:2] : '0;
    if_resp_valid = state == RESP && gnt_q == GNT_IF;
    ld_resp_valid = state == RESP && gnt_q == GNT_LD;
    busy          = state != IDLE;
  end
  assign if_resp_data = resp_q;
  assign ld_resp_data = resp_q;
endmodule

// File: doc/bios_arbiter.md
# bios_arbiter

Shares the single synchronous read port of the BIOS ROM between the instruction-fetch requester (IF) and the data-load requester (LD). The block uses a valid/ready request and response handshake on each side and arbitrates round-robin. It also applies the existing BIOS byte-offset right-shift to returned data. It sits between the core's fetch/load units and the BIOS memory, and replaces direct dual-port access.

## Interface
Parameters:
- ADDR_W, 13, byte address width; the word address is ADDR_W-2 bits
- DATA_W, 32, data word width

Ports:
- clk  in  1  clock; one clock; reset is asynchronous and active-low
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  IF read request
- if_req_ready  out  1  IF request accepted this cycle
- if_req_addr  in  ADDR_W  IF byte address
- if_resp_valid  out  1  IF response data valid
- if_resp_ready  in  1  IF consumes the response
- if_resp_data  out  DATA_W  IF aligned read data
- ld_req_valid, ld_req_ready, ld_req_addr, ld_resp_valid, ld_resp_ready, ld_resp_data  same directions and widths as the if_* ports, for LD
- mem_en  out  1  ROM read enable
- mem_addr  out  ADDR_W-2  ROM word address
- mem_rdata  in  DATA_W  ROM data, valid the cycle after mem_en
- busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, READ, CAPT, RESP.
- **IDLE**
  - If any req_valid is high, pick the winner.
  - If both are valid, the winner is the requester not granted last.
  - Assert the winner's req_ready combinationally. The loser's req_ready stays 0.
  - On the accept edge: latch addr, offset = addr[1:0], and the grant id. Update last_grant. Go to READ.
- **READ**: drive mem_en=1 and mem_addr=latched addr[ADDR_W-1:2]. Go to CAPT.
- **CAPT**
  - Register the shifted mem_rdata into the response register. Go to RESP.
  - Offset 00 returns the word unchanged.
  - Offset 01 returns {8'b0, w[31:8]}.
  - Offset 10 returns {16'b0, w[31:16]}.
  - Offset 11 returns {24'b0, w[31:24]}.
- **RESP**
  - Assert resp_valid for the granted requester only. Hold data stable until that requester's resp_ready is high.
  - On the handshake edge, drop resp_valid and go to IDLE.
- Only one transaction is in flight. Requests arriving outside IDLE see req_ready=0 and must hold valid.
- Both resp_data outputs always carry the response register. Only resp_valid is steered.

## Timing
- Reset values:
  - state=IDLE
  - last_grant=LD, so IF wins the first tie
  - all req_ready, resp_valid and mem_en are 0
  - resp_data=0
  - mem_addr=0
  - busy=0
- Latency: accept at cycle 0 → mem_en in cycle 1 → capture in cycle 2 → resp_valid in cycle 3.
- Minimum turnaround is 4 cycles per transaction when resp_ready is held high.
- Backpressure: resp_valid stays high and data stays fixed for any number of cycles until resp_ready.
- Next accept is possible in the cycle after the response handshake.
- req_ready depends combinationally on the valids in IDLE; there is no path from the ready inputs to req_ready.
- Simultaneous IF and LD valid: grants strictly alternate. A single requester that is always valid is granted back to back.
- resp_ready asserted before resp_valid has no effect.
- Address wrap: mem_addr is the truncated word index, with no overflow logic.
- rst_n assertion mid-transaction:
  - Immediately returns to IDLE and clears all valids and mem_en.
  - Drops the in-flight request with no response.
  - Requesters reissue after reset.

## Structure
- Shared package bios_arb_pkg holds:
  - the state enum: IDLE=2'd0, READ=2'd1, CAPT=2'd2, RESP=2'd3
  - the grant ids GNT_IF=1'b0, GNT_LD=1'b1
  - the function byte_align(word, offset) implementing the shift above; other BIOS/IMEM paths reuse it.
- One sub-module is natural: rr_arb2, a two-input round-robin arbiter.
  - Inputs: valids, last_grant, enable.
  - Outputs: one-hot grant and winner id.
  - Purely combinational; last_grant is stored in bios_arbiter.

## Test plan
- Reset, then IF-only read of addr 0x004 with ROM word[1]=0xDEADBEEF and resp_ready=1 → if_req_ready in cycle 0, mem_en with mem_addr=1 in cycle 1, if_resp_valid with data 0xDEADBEEF in cycle 3, ld_resp_valid never asserted.
- Both valid at reset, IF addr 0x000, LD addr 0x008 → IF served first, then LD. Then both valid again → IF served again, since last_grant is now LD.
- LD read of 0x00B with ROM word[2]=0x11223344 → ld_resp_data=0x00000011. Offsets 01 and 10 on the same word give 0x00112233 and 0x00001122.
- IF response with resp_ready low for 5 cycles → if_resp_valid and data stable for those 5 cycles, busy=1, and a new LD request sees ld_req_ready=0 throughout.
- rst_n pulsed low during CAPT → outputs go to their reset values asynchronously, no response is ever delivered, and the next request completes normally with 3-cycle latency.
- Continuous IF valid alone, resp_ready=1, 4 transactions → accepts at cycles 0, 4, 8 and 12.
